// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types and constants for the branch resolve unit
package bru_pkg;

   localparam int BRU_XLEN = 32;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [BRU_XLEN-1:0] pc;
      logic                taken;
      logic [BRU_XLEN-1:0] target;
   } pred_entry_t;

   typedef enum logic {
      ACTIVE  = 1'b0,
      RECOVER = 1'b1
   } bru_state_t;

endpackage

// File: rtl/bru_fifo.sv
// rtl/bru_fifo.sv - in-order prediction queue with push/pop/clear
module bru_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  pred_entry_t              wr_data,
   output pred_entry_t              rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   pred_entry_t     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointer wrap is the natural overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves queued predictions against EX outcomes
// Optional perf counters enabled by BRU_PERF_CNT_EN.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter int XLEN           = BRU_XLEN
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pred_valid,
   input  logic [XLEN-1:0]           pred_pc,
   input  logic                      pred_taken,
   input  logic [XLEN-1:0]           pred_target,
   output logic                      pred_ready,
   input  logic                      res_valid,
   input  logic                      res_taken,
   input  logic [XLEN-1:0]           res_target,
   output logic                      redirect_valid,
   output logic [XLEN-1:0]           redirect_pc,
   output logic                      flush,
   output logic                      upd_valid,
   output logic [7:0]                upd_idx,
   output logic                      upd_taken,
   output logic                      res_err,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic [31:0]               perf_resolved,
   output logic [31:0]               perf_mispredict
);

   localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

   bru_state_t     state, state_nxt;
   logic [RCW-1:0] rcnt, rcnt_nxt;
   pred_entry_t    wr_entry, head;
   logic           full, empty;
   logic           push, resolve, mispredict, clear;

   assign pred_ready = (state == ACTIVE) && !full;
   assign push       = pred_valid && pred_ready;
   assign resolve    = (state == ACTIVE) && res_valid && !empty;
   assign mispredict = (res_taken != head.taken) || (res_taken && (res_target != head.target));
   assign clear      = resolve && mispredict;

   assign wr_entry.pc     = pred_pc;
   assign wr_entry.taken  = pred_taken;
   assign wr_entry.target = pred_target;

   bru_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (resolve),
      .clear   (clear),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (occupancy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACTIVE;
         rcnt  <= '0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      case (state)
         ACTIVE: begin
            if (clear && (RECOVER_CYCLES != 0)) begin
               state_nxt = RECOVER;
               rcnt_nxt  = RCW'(RECOVER_CYCLES);
            end
         end
         RECOVER: begin
            rcnt_nxt = rcnt - 1'b1;
            if (rcnt == RCW'(1)) state_nxt = ACTIVE;
         end
         default: state_nxt = ACTIVE;
      endcase
   end

   // Result outputs are registered one cycle behind res_valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upd_valid      <= 1'b0;
         upd_idx        <= '0;
         upd_taken      <= 1'b0;
         redirect_valid <= 1'b0;
         flush          <= 1'b0;
         redirect_pc    <= '0;
         res_err        <= 1'b0;
      end else begin
         upd_valid      <= resolve;
         redirect_valid <= clear;
         flush          <= clear;
         res_err        <= (state == ACTIVE) && res_valid && empty;
         if (resolve) begin
            upd_idx   <= head.pc[7:0];
            upd_taken <= res_taken;
         end
         if (clear) redirect_pc <= res_taken ? res_target : head.pc + XLEN'(4);
      end
   end

`ifdef BRU_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_resolved   <= '0;
         perf_mispredict <= '0;
      end else begin
         if (resolve && (perf_resolved != 32'hFFFF_FFFF))
            perf_resolved <= perf_resolved + 1'b1;
         if (clear && (perf_mispredict != 32'hFFFF_FFFF))
            perf_mispredict <= perf_mispredict + 1'b1;
      end
   end
`else
   assign perf_resolved   = '0;
   assign perf_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

   typedef struct {
      bit        upd;
      bit [7:0]  idx;
      bit        taken;
      bit        redir;
      bit [31:0] rpc;
      bit        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid, pred_taken, pred_ready;
   logic [31:0] pred_pc, pred_target;
   logic        res_valid, res_taken;
   logic [31:0] res_target;
   logic        redirect_valid, flush, upd_valid, upd_taken, res_err;
   logic [31:0] redirect_pc;
   logic [7:0]  upd_idx;
   logic [2:0]  occupancy;
   logic [31:0] perf_resolved, perf_mispredict;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(4), .RECOVER_CYCLES(2), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .res_err(res_err), .occupancy(occupancy),
      .perf_resolved(perf_resolved), .perf_mispredict(perf_mispredict)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
      pred_valid = 1'b1; pred_pc = pc; pred_taken = t; pred_target = tgt;
      tick();
      pred_valid = 1'b0;
   endtask

   task automatic resolve(input bit t, input logic [31:0] tgt);
      res_valid = 1'b1; res_taken = t; res_target = tgt;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic exp_out(input bit upd, input bit [7:0] idx, input bit t,
                          input bit redir, input bit [31:0] rpc, input bit err);
      exp_t e;
      e.upd = upd; e.idx = idx; e.taken = t; e.redir = redir; e.rpc = rpc; e.err = err;
      exp_q.push_back(e);
   endtask

   // Monitor: every output event must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && (upd_valid || res_err || redirect_valid || flush)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out: upd=%0b err=%0b redir=%0b flush=%0b, expected no event",
                     upd_valid, res_err, redirect_valid, flush);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (upd_valid !== e.upd || res_err !== e.err || redirect_valid !== e.redir ||
                flush !== e.redir || (e.upd && (upd_idx !== e.idx || upd_taken !== e.taken)) ||
                (e.redir && redirect_pc !== e.rpc)) begin
               fails++;
               $display("FAIL result: got upd=%0b idx=%0h tk=%0b redir=%0b flush=%0b pc=%0h err=%0b, expected upd=%0b idx=%0h tk=%0b redir=%0b pc=%0h err=%0b",
                        upd_valid, upd_idx, upd_taken, redirect_valid, flush, redirect_pc, res_err,
                        e.upd, e.idx, e.taken, e.redir, e.rpc, e.err);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
      #1;
      check("rst_pred_ready", pred_ready, 1);
      check("rst_occupancy", occupancy, 0);
      check("rst_upd_valid", upd_valid, 0);
      check("rst_redirect", redirect_valid, 0);
      check("rst_flush", flush, 0);
      check("rst_res_err", res_err, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      #12 rst = 1'b0;
      tick();

      // Correct taken prediction
      enq(32'h40, 1, 32'h80);
      check("t1_occ", occupancy, 1);
      exp_out(1, 8'h40, 1, 0, 0, 0);
      resolve(1, 32'h80);
      check("t1_occ_after", occupancy, 0);
      tick();

      // Not-taken predicted, actually taken; RECOVER ignores res_valid
      enq(32'h10, 0, 32'h0);
      exp_out(1, 8'h10, 1, 1, 32'h30, 0);
      resolve(1, 32'h30);
      check("t2_ready_rec0", pred_ready, 0);
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      check("t2_ready_rec1", pred_ready, 0);
      tick();
      check("t2_ready_back", pred_ready, 1);

      // Taken predicted, actually not taken -> fall-through
      enq(32'h20, 1, 32'h50);
      exp_out(1, 8'h20, 0, 1, 32'h24, 0);
      resolve(0, 32'h0);
      check("t3_occ", occupancy, 0);
      tick(); tick();
      check("t3_ready_back", pred_ready, 1);

      // Fill, then resolve with a blocked push in the same cycle
      for (int i = 0; i < 4; i++) enq(32'h100 + 4*i, 0, 32'h0);
      check("t4_full_ready", pred_ready, 0);
      check("t4_full_occ", occupancy, 4);
      pred_valid = 1'b1; pred_pc = 32'h200; pred_taken = 0;
      exp_out(1, 8'h00, 0, 0, 0, 0);
      resolve(0, 32'h0);
      pred_valid = 1'b0;
      check("t4_occ3", occupancy, 3);
      for (int i = 1; i < 4; i++) begin
         exp_out(1, 8'(4*i), 0, 0, 0, 0);
         resolve(0, 32'h0);
      end
      check("t4_drained", occupancy, 0);

      // Resolve on empty queue
      exp_out(0, 0, 0, 0, 0, 1);
      resolve(1, 32'h44);
      tick();

      // Enqueue and pop in the same cycle
      enq(32'h60, 0, 32'h0);
      pred_valid = 1'b1; pred_pc = 32'h64; pred_taken = 0;
      exp_out(1, 8'h60, 0, 0, 0, 0);
      resolve(0, 32'h0);
      pred_valid = 1'b0;
      check("t6_occ_same", occupancy, 1);
      exp_out(1, 8'h64, 0, 0, 0, 0);
      resolve(0, 32'h0);
      check("t6_occ_empty", occupancy, 0);
      tick();

      // Asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++) enq(32'h70 + 4*i, 1, 32'h90);
      check("t7_occ3", occupancy, 3);
      rst = 1'b1;
      #1;
      check("t7_rst_occ", occupancy, 0);
      #1 rst = 1'b0;
      tick();

      // Asynchronous reset in RECOVER while redirect pulse is high
      for (int i = 0; i < 3; i++) enq(32'h70 + 4*i, 1, 32'h90);
      res_valid = 1'b1; res_taken = 0; res_target = 0;
      @(posedge clk);
      res_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("t8_rst_occ", occupancy, 0);
      check("t8_rst_ready", pred_ready, 1);
      check("t8_rst_redirect", redirect_valid, 0);
      check("t8_rst_flush", flush, 0);
      check("t8_rst_upd", upd_valid, 0);
      check("t8_rst_err", res_err, 0);
      #1 rst = 1'b0;
      tick(); tick();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-side partner of the fetch-time branch predictor.
- Queues each prediction issued at fetch, in program order.
- Compares the queued prediction against the resolved outcome from EX.
- On mismatch, issues a registered redirect and pipeline flush, then drains wrong-path results.
- Drives the predictor update interface (valid, 8-bit index, taken).

Parameters:
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
RECOVER_CYCLES, 2, cycles spent in RECOVER after a mispredict
XLEN, 32, PC/target width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pred_valid  in  1  fetch issued a prediction this cycle
pred_pc  in  XLEN  PC of predicted control-flow instruction
pred_taken  in  1  predicted direction
pred_target  in  XLEN  predicted target (ignored when not taken)
pred_ready  out  1  queue can accept a prediction
res_valid  in  1  EX resolved the oldest control-flow instruction
res_taken  in  1  actual direction
res_target  in  XLEN  actual target
redirect_valid  out  1  one-cycle pulse: refetch from redirect_pc
redirect_pc  out  XLEN  correct next PC
flush  out  1  one-cycle pulse with redirect_valid: kill younger instructions
upd_valid  out  1  one-cycle predictor update strobe
upd_idx  out  8  head pred_pc[7:0]
upd_taken  out  1  actual direction for training
res_err  out  1  one-cycle pulse: res_valid with empty queue
occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Reset values: all outputs 0, except pred_ready=1. Queue is empty, state is ACTIVE.
- pred_ready = (state==ACTIVE) && (count<DEPTH).
- Enqueue when pred_valid && pred_ready.
- ACTIVE, res_valid with queue non-empty:
  - Pop the head and compare.
  - mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
  - All result outputs are registered and appear 1 cycle after res_valid.
  - upd_valid=1, upd_idx=head.pc[7:0], upd_taken=res_taken on every resolve.
  - On mispredict:
    - redirect_valid=flush=1, redirect_pc = res_taken ? res_target : head.pc+4 (wraps mod 2^XLEN).
    - Queue cleared (an enqueue in the same cycle is discarded).
    - state goes to RECOVER and the counter loads RECOVER_CYCLES.
  - Correct prediction: no redirect.
- Enqueue and pop in the same cycle (non-full): both take effect, count unchanged.
- res_valid with queue empty: res_err pulses next cycle; no update, no redirect, state unchanged.
- RECOVER:
  - pred_ready=0; res_valid is ignored (wrong path, no res_err).
  - Counter decrements each cycle; at 1 → ACTIVE.
  - RECOVER_CYCLES=0 skips RECOVER entirely.
- Pointers wrap modulo DEPTH. Full means count==DEPTH.
- rst asserted mid-operation: queue empties and pulses drop immediately (asynchronous).

Optional Feature:
BRU_PERF_CNT_EN:
- Defined: adds outputs perf_resolved[31:0] and perf_mispredict[31:0].
  - Both increment on each counted resolve and mispredict; both saturate at 0xFFFFFFFF.
  - Both reset to 0.
- Undefined: the ports are still present and tied to 0; no counter flops.

Decomposition:
- Package bru_pkg:
  - Control-flow opcode constants: BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111.
  - pred_entry_t {pc, taken, target}.
  - state enum {ACTIVE, RECOVER}.
- Sub-module bru_fifo: parameterized synchronous FIFO of pred_entry_t with push/pop/clear, full/empty, count.

Test Plan:
- Enqueue pc=0x40 taken, target=0x80; resolve taken, 0x80 → no redirect; upd_valid=1, upd_idx=0x40, upd_taken=1 one cycle later.
- Enqueue pc=0x10 not-taken; resolve taken, target 0x30 → redirect_valid=flush=1, redirect_pc=0x30; pred_ready=0 for 2 cycles, then 1.
- Enqueue pc=0x20 taken, target 0x50; resolve not-taken → redirect_pc=0x24, occupancy=0.
- Fill 4 entries → pred_ready=0; simultaneous resolve (correct) plus pred_valid → push blocked that cycle, occupancy 3 next cycle.
- res_valid with empty queue → res_err=1 for one cycle, upd_valid=0.
- Assert rst while occupancy=3 and state RECOVER → occupancy=0, pred_ready=1, all pulses 0 without a clock edge.
